// File: rtl/ws_feeder4x4.sv
// Weight-stationary feeder for a depth x depth systolic array: loads one weight
// column per beat, then streams input vectors with a per-lane diagonal skew.
module ws_feeder4x4 #(
    parameter int bit_width    = 8,
    parameter int depth        = 4,
    parameter int drain_cycles = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [7:0]                     vec_count,
    input  logic [bit_width*depth-1:0]     wt_in,
    input  logic                           wt_valid,
    output logic                           wt_ready,
    input  logic [bit_width*depth-1:0]     data_in,
    input  logic                           data_valid,
    output logic                           data_ready,
    output logic                           control,
    output logic [bit_width*depth-1:0]     wt_arr,
    output logic [bit_width*depth-1:0]     data_arr,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, DRAIN, DONE} state_t;

    localparam int beat_w  = $clog2(depth + 1);
    localparam int drain_w = $clog2(drain_cycles + 1);

    state_t               state, state_nx;
    logic [7:0]           vec_total;
    logic [7:0]           vec_cnt;
    logic [beat_w-1:0]    beat_cnt;
    logic [drain_w-1:0]   drain_cnt;
    logic                 wt_acc, data_acc, last_beat, last_vec, drain_end;

    assign wt_ready   = (state == LOAD_WT);
    assign data_ready = (state == STREAM);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign wt_acc    = wt_valid && wt_ready;
    assign data_acc  = data_valid && data_ready;
    assign last_beat = wt_acc && (beat_cnt == beat_w'(depth - 1));
    assign last_vec  = data_acc && (vec_cnt == vec_total - 8'd1);
    assign drain_end = (state == DRAIN) && (drain_cnt == drain_w'(drain_cycles - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: state_nx gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_WT;
            LOAD_WT: if (last_beat) state_nx = (vec_total == 8'd0) ? DRAIN : STREAM;
            STREAM:  if (last_vec) state_nx = DRAIN;
            DRAIN:   if (drain_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_total <= '0;
            vec_cnt   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                vec_total <= vec_count;
                vec_cnt   <= '0;
                beat_cnt  <= '0;
            end
            if (wt_acc)   beat_cnt <= beat_cnt + beat_w'(1);
            if (data_acc) vec_cnt  <= vec_cnt + 8'd1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + drain_w'(1) : '0;
        end
    end

    // Weight path: one-cycle echo of each accepted beat, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            control <= 1'b0;
            wt_arr  <= '0;
        end else begin
            control <= wt_acc;
            wt_arr  <= wt_acc ? wt_in : '0;
        end
    end

    // Lane k is delayed by k+1 registers; idle cycles feed zero bubbles.
    for (genvar k = 0; k < depth; k++) begin : g_lane
        logic [bit_width-1:0] chain [k+1];

        // NOTE: the skew registers are reset so an aborted job leaves no
        // stale lane data to leak onto data_arr.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= k; s++) chain[s] <= '0;
            end else begin
                chain[0] <= data_acc ? data_in[k*bit_width +: bit_width] : '0;
                for (int s = 1; s <= k; s++) chain[s] <= chain[s-1];
            end
        end

        assign data_arr[k*bit_width +: bit_width] = chain[k];
    end

endmodule

// File: tb/tb_ws_feeder4x4.sv
// Scoreboard bench for ws_feeder4x4: stimulus tasks queue expected weight echoes,
// skewed lane bytes and done cycles; a negedge monitor pops and compares them.
module tb_ws_feeder4x4;

    typedef struct { int cyc; int lane; logic [7:0] val; } lane_exp_t;
    typedef struct { int cyc; logic [31:0] val; } wt_exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, wt_valid, data_valid;
    logic [7:0]  vec_count;
    logic [31:0] wt_in, data_in;
    logic        wt_ready, data_ready, control, busy, done;
    logic [31:0] wt_arr, data_arr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    bit mon_en = 1'b0;

    lane_exp_t   lq[$];
    wt_exp_t     wq[$];
    int          doneq[$];
    logic [31:0] wts [4];

    ws_feeder4x4 #(.bit_width(8), .depth(4), .drain_cycles(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_count(vec_count),
        .wt_in(wt_in), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs against queued expectations each cycle.
    always @(negedge clk) begin : monitor
        wt_exp_t    w;
        int         dc;
        int         idx;
        logic [7:0] got;
        if (mon_en) begin
            if (control) begin
                check("ctrl_data_zero", data_arr, 32'h0);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("wt_cycle", cyc, w.cyc);
                    check("wt_arr", wt_arr, w.val);
                end else begin
                    check("ctrl_unexp", {31'b0, control}, 32'h0);
                end
            end else begin
                check("wt_arr_idle", wt_arr, 32'h0);
            end
            if (done) begin
                if (doneq.size() > 0) begin
                    dc = doneq.pop_front();
                    check("done_cycle", cyc, dc);
                end else begin
                    check("done_unexp", {31'b0, done}, 32'h0);
                end
            end
            for (int k = 0; k < 4; k++) begin
                got = data_arr[k*8 +: 8];
                idx = -1;
                for (int i = 0; i < lq.size(); i++) begin
                    if (lq[i].cyc == cyc && lq[i].lane == k) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0) begin
                    check($sformatf("lane%0d", k), {24'b0, got}, {24'b0, lq[idx].val});
                    lq.delete(idx);
                end else if (got != 8'h0) begin
                    check($sformatf("lane%0d_bubble", k), {24'b0, got}, 32'h0);
                end
            end
        end
    end

    task automatic start_job(input logic [7:0] vc);
        check("idle_before_start", {31'b0, busy}, 32'h0);
        start     = 1'b1;
        vec_count = vc;
        step();
        start     = 1'b0;
        vec_count = 8'hA5;
        check("busy_after_start", {31'b0, busy}, 32'h1);
        check("wt_ready_load", {31'b0, wt_ready}, 32'h1);
    endtask

    task automatic load_weights(input int gap);
        int      n;
        wt_exp_t e;
        for (int b = 0; b < 4; b++) begin
            wt_in    = wts[b];
            wt_valid = 1'b1;
            n = 0;
            while (!wt_ready && n < 20) begin
                step();
                n++;
            end
            check("wt_ready_wait", {31'b0, wt_ready}, 32'h1);
            e.cyc = cyc + 1;
            e.val = wts[b];
            wq.push_back(e);
            last_acc = cyc;
            step();
            wt_valid = 1'b0;
            wt_in    = 32'h0;
            if (b < 3) repeat (gap) step();
        end
    endtask

    task automatic send_vec(input logic [31:0] v, input int gap);
        int        n;
        lane_exp_t e;
        data_in    = v;
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 20) begin
            step();
            n++;
        end
        check("data_ready_wait", {31'b0, data_ready}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            e.cyc  = cyc + k + 1;
            e.lane = k;
            e.val  = v[k*8 +: 8];
            lq.push_back(e);
        end
        last_acc = cyc;
        step();
        data_valid = 1'b0;
        data_in    = 32'h0;
        repeat (gap) step();
    endtask

    // DRAIN starts the cycle after the last accepted beat; done follows 7 later.
    task automatic end_job();
        int n;
        bit dr_seen;
        doneq.push_back(last_acc + 8);
        check("drain_busy", {31'b0, busy}, 32'h1);
        dr_seen = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            if (data_ready) dr_seen = 1'b1;
            step();
            n++;
        end
        check("dr_in_drain", {31'b0, dr_seen}, 32'h0);
        check("job_idle", {31'b0, busy}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_control"}, {31'b0, control}, 32'h0);
        check({tag, "_wt_arr"}, wt_arr, 32'h0);
        check({tag, "_data_arr"}, data_arr, 32'h0);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_wt_ready"}, {31'b0, wt_ready}, 32'h0);
        check({tag, "_data_ready"}, {31'b0, data_ready}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wts[0] = 32'h04030201;
        wts[1] = 32'h08070605;
        wts[2] = 32'h0C0B0A09;
        wts[3] = 32'h100F0E0D;
        rst_n = 1'b0; start = 1'b0; vec_count = 8'h0;
        wt_in = 32'h0; wt_valid = 1'b0; data_in = 32'h0; data_valid = 1'b0;
        repeat (2) step();
        mon_en = 1'b1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Back-to-back weight load, single vector skew.
        start_job(8'd1);
        load_weights(0);
        check("stream_after_load", {31'b0, data_ready}, 32'h1);
        send_vec(32'h44332211, 0);
        end_job();

        // Stalls on both weight and data handshakes.
        start_job(8'd3);
        load_weights(2);
        send_vec(32'h0A0B0C0D, 2);
        send_vec(32'h1A1B1C1D, 2);
        send_vec(32'h2A2B2C2D, 0);
        end_job();

        // Zero-length job goes straight to DRAIN.
        start_job(8'd0);
        load_weights(0);
        check("zero_len_dr", {31'b0, data_ready}, 32'h0);
        end_job();

        // Abort mid-STREAM after two vectors.
        start_job(8'd4);
        load_weights(0);
        send_vec(32'h55667788, 0);
        send_vec(32'h99AABBCC, 0);
        rst_n = 1'b0;
        for (int i = lq.size() - 1; i >= 0; i--) if (lq[i].cyc > cyc) lq.delete(i);
        step();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        step();
        start_job(8'd2);
        load_weights(0);
        send_vec(32'h13243546, 0);
        send_vec(32'h57687980, 0);
        end_job();

        // start and wt_valid during STREAM have no effect.
        start_job(8'd3);
        load_weights(0);
        start = 1'b1; wt_valid = 1'b1; wt_in = 32'hDEADBEEF; vec_count = 8'd0;
        repeat (2) begin
            step();
            check("illegal_dr", {31'b0, data_ready}, 32'h1);
            check("illegal_wt_ready", {31'b0, wt_ready}, 32'h0);
        end
        start = 1'b0; wt_valid = 1'b0; wt_in = 32'h0;
        send_vec(32'h61626364, 0);
        send_vec(32'h71727374, 1);
        send_vec(32'h81828384, 0);
        end_job();

        // Longest job: 255 vectors, counter must not wrap.
        start_job(8'd255);
        load_weights(0);
        for (int i = 0; i < 255; i++) send_vec({4{8'(i + 1)}}, 0);
        end_job();

        repeat (3) step();
        check("wt_q_empty", wq.size(), 32'h0);
        check("lane_q_empty", lq.size(), 32'h0);
        check("done_q_empty", doneq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws_feeder4x4.md
WS_FEEDER4X4 -- requirements
Module: ws_feeder4x4

Interface
REQ-001 Parameter bit_width, default 8, width of one weight or data element.
REQ-002 Parameter depth, default 4, number of lanes (array rows and columns).
REQ-003 Parameter drain_cycles, default 7, number of zero-injection cycles after the last data vector.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset (polarity and synchronicity are fixed).
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  pulse that begins a tile job; sampled only in IDLE.
REQ-008 vec_count  in  8  number of data vectors in the job; latched on accepted start.
REQ-009 wt_in  in  bit_width*depth  one weight column; byte k is row k.
REQ-010 wt_valid / wt_ready  in / out  1  weight beat handshake.
REQ-011 data_in  in  bit_width*depth  one input vector; byte k is lane k.
REQ-012 data_valid / data_ready  in / out  1  data beat handshake.
REQ-013 control  out  1  array weight-load enable; registered.
REQ-014 wt_arr  out  bit_width*depth  weight bus to the array; registered.
REQ-015 data_arr  out  bit_width*depth  skewed data bus to the array; registered.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse at job completion.

Function
REQ-018 FSM states: IDLE, LOAD_WT, STREAM, DRAIN, DONE.
REQ-019 IDLE -> LOAD_WT on start=1; in the same cycle, latch vec_count and clear the beat and vector counters.
REQ-020 LOAD_WT: wt_ready=1; a beat transfers when wt_valid&wt_ready; exactly depth beats are accepted; after the depth-th beat, go to STREAM (vec_count>0) or DRAIN (vec_count=0).
REQ-021 For each accepted weight beat, the next cycle SHALL show control=1 and wt_arr=that beat; in all other cycles, control=0 and wt_arr=0.
REQ-022 Weight beats SHALL be forwarded in arrival order; the host supplies the column destined for the farthest column first.
REQ-023 STREAM: data_ready=1; data_ready=0 in all other states; a beat transfers when data_valid&data_ready.
REQ-024 STREAM -> DRAIN in the cycle the vec_count-th beat is accepted.
REQ-025 Skew: lane k of an accepted vector SHALL appear on data_arr byte k exactly k+1 cycles after acceptance (lane 0: +1, lane 3: +4).
REQ-026 Skew is implemented as a per-lane shift chain of k+1 registers.
REQ-027 A cycle without an accepted beat SHALL insert a zero bubble into every lane chain; no data is duplicated.
REQ-028 DRAIN: inject zeros for exactly drain_cycles cycles, then go to DONE.
REQ-029 DONE: assert done=1 for one cycle, then return to IDLE.
REQ-030 data_arr SHALL be 0 whenever control=1, since weight-load and data phases never overlap.
REQ-031 start SHALL be ignored outside IDLE.
REQ-032 wt_valid SHALL be ignored outside LOAD_WT, and data_valid outside STREAM.
REQ-033 Handshake stalls (valid low) SHALL NOT advance the beat or vector counters.
REQ-034 The vector counter SHALL be 8 bits; vec_count=255 completes without wrap.

Reset
REQ-035 On rst_n=0 at posedge, the block SHALL enter IDLE.
REQ-036 Reset values: control=0, wt_arr=0, data_arr=0, all skew registers 0, counters 0, busy=0, done=0, wt_ready=0, data_ready=0.
REQ-037 Reset mid-job (any state) SHALL abort the job without a done pulse; the first post-reset cycle SHALL show all outputs at their reset values.

Verification
REQ-038 Weight load: start, four back-to-back beats 0x04030201..0x100F0E0D -> control=1 for 4 consecutive cycles, wt_arr echoes each beat one cycle later, then STREAM.
REQ-039 Skew: vec_count=1, data_in=0x44332211 -> data_arr bytes 0x11 at +1, 0x22 at +2, 0x33 at +3, 0x44 at +4; all other lane bytes 0.
REQ-040 Stall: vec_count=3, data_valid low for 2 cycles between vectors -> 2-cycle zero bubble in every lane; done occurs 7 cycles after the DRAIN entry cycle.
REQ-041 Zero-length job: vec_count=0 -> after weight load, 7 DRAIN cycles, done pulse; data_ready never high.
REQ-042 Reset mid-STREAM after 2 vectors -> next cycle IDLE, data_arr=0, busy=0, no done pulse; a new start then runs normally.
REQ-043 Illegal inputs: start asserted during STREAM, and wt_valid asserted during STREAM -> no effect on state, counters or outputs.
